regfile_port_sched: RTL and testbench
=====================================

// Module: regfile_port_sched
// PURPOSE
//  Schedules access to the 32-entry integer register file (x0..x31), which has one read port and one write port.
//  - Shares the read port between NREQ requesters using round-robin arbitration.
//  - Forwards the single write-back stream to the write port and suppresses writes to x0.
//  - After reset, sweeps x1..x31 to zero, because the storage registers have no reset of their own.
//  - Sits between decode/debug requesters and the register file.
// PARAMETERS
//  NREQ      2   number of read requesters (1..4)
//  XLEN      32  register data width
//  CLR_INIT  1   1 = run the zero-sweep after reset; 0 = enter RUN directly
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high reset
//  rd_req     in   NREQ       per-requester read request; held until granted
//  rd_addr    in   NREQ*5     per-requester register index; requester i uses [5i+4:5i]
//  rd_gnt     out  NREQ       one-hot grant, combinational, issued in the same cycle as rf_ren
//  rd_valid   out  NREQ       one-hot, registered; read data is returned for the granted requester
//  rd_data    out  XLEN       read data, shared by all requesters, qualified by rd_valid
//  wr_req     in   1          write-back request
//  wr_addr    in   5          write-back register index
//  wr_data    in   XLEN       write-back data
//  wr_ack     out  1          combinational; write accepted this cycle
//  rf_ren     out  1          register file read enable
//  rf_raddr   out  5          register file read address
//  rf_rdata   in   XLEN       register file read data, valid 1 cycle after rf_ren
//  rf_we      out  1          register file write enable
//  rf_waddr   out  5          register file write address
//  rf_wdata   out  XLEN       register file write data
//  busy       out  1          high while in INIT
// BEHAVIOUR
//  FSM states: INIT, RUN.
//  - reset -> INIT when CLR_INIT=1, otherwise reset -> RUN.
//  - INIT -> RUN after the cycle that writes x31.
//  INIT:
//  - sweep counter starts at 1.
//  - each cycle: rf_we=1, rf_waddr=counter, rf_wdata=0, then counter increments.
//  - the sweep covers x1..x31 and takes 31 cycles.
//  - rd_gnt=0, wr_ack=0, busy=1.
//  Reset values:
//  - rd_gnt=0, rd_valid=0, rd_data=0, wr_ack=0, rf_ren=0, rf_we=0.
//  - round-robin pointer=0.
//  - busy=CLR_INIT.
//  Read arbitration (RUN):
//  - search starts at the pointer and wraps modulo NREQ; the first requester with rd_req set wins.
//  - winner i: rd_gnt[i]=1, rf_ren=1, rf_raddr=rd_addr[i].
//  - pointer <= (i+1) mod NREQ. The pointer does not change when no request is granted.
//  - at most one grant per cycle; the throughput is 1 read per cycle.
//  - a requester drops or changes rd_req the cycle after its grant.
//  Read return:
//  - latency is exactly 1 cycle: cycle N+1 has rd_valid[i]=1 and rd_data=rf_rdata.
//  - rd_valid is a 1-cycle pulse.
//  - when the granted address is x0, rd_data=0 regardless of rf_rdata.
//  Write (RUN):
//  - wr_ack=wr_req.
//  - rf_we=wr_req & (wr_addr!=0); rf_waddr=wr_addr; rf_wdata=wr_data.
//  - a write to x0 is acked and discarded.
//  - a write never stalls a read, and a read never stalls a write.
//  Same-cycle read and write to the same address: the register file returns the old value (read-before-write).
//  Reset mid-operation:
//  - a pending rd_valid is dropped and the grant pointer is cleared.
//  - INIT restarts from x1.
// CONFIGURATION
//  REGFILE_SCHED_BYPASS_EN defined:
//  - condition: a grant in cycle N and an accepted write in cycle N to the same nonzero address.
//  - the grant cycle registers wr_data.
//  - cycle N+1 returns that registered wr_data on rd_data instead of rf_rdata.
//  - adds one XLEN register and a 5-bit compare.
//  REGFILE_SCHED_BYPASS_EN not defined: no forwarding; read-before-write as above.
// TESTING
//  T1 reset, CLR_INIT=1:
//  - stimulus: apply reset.
//  - expect: busy=1 for 31 cycles; rf_we writes 0 to x1..x31 in order; no rd_gnt during the sweep; then busy=0.
//  T2 contention, NREQ=2, rd_req=2'b11 held, addresses 5 and 6:
//  - grants alternate 01,10,01,...
//  - each rd_valid follows its grant by 1 cycle with the rf_rdata of that cycle.
//  T3 x0 handling:
//  - write x0 with 0xDEADBEEF -> wr_ack=1, rf_we=0.
//  - read x0 with the model returning 0xFFFFFFFF -> rd_data=0.
//  T4 hazard, write x7=0x1234 and read x7 in the same cycle (x7 previously 0xAAAA):
//  - rd_data=0xAAAA without the macro, 0x1234 with REGFILE_SCHED_BYPASS_EN.
//  T5 reset in RUN, asserted in the cycle after a grant:
//  - rd_valid stays 0, busy=1 the next cycle, sweep restarts at x1, pointer=0.
//  T6 single requester, rd_req[1] only:
//  - granted every cycle; the pointer still wraps; no grant appears on requester 0.

Source files
------------

// File: rtl/regfile_port_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_sched_if
// Description : Bundle of requester, write-back and register-file signals
//               used by regfile_port_sched.
//               master : requester / write-back / register-file side
//               slave  : the scheduler itself
//               Read side  : rd_req, rd_addr -> rd_gnt, rd_valid, rd_data
//               Write side : wr_req, wr_addr, wr_data -> wr_ack
//               RF side    : rf_ren, rf_raddr, rf_we, rf_waddr, rf_wdata,
//                            rf_rdata (returned one cycle after rf_ren)
//               Status     : busy (zero-sweep in progress)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_port_sched_if #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]   rd_req;
    logic [NREQ*5-1:0] rd_addr;
    logic [NREQ-1:0]   rd_gnt;
    logic [NREQ-1:0]   rd_valid;
    logic [XLEN-1:0]   rd_data;
    logic              wr_req;
    logic [4:0]        wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              wr_ack;
    logic              rf_ren;
    logic [4:0]        rf_raddr;
    logic [XLEN-1:0]   rf_rdata;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              busy;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, rf_rdata,
        input  rd_gnt, rd_valid, rd_data, wr_ack,
               rf_ren, rf_raddr, rf_we, rf_waddr, rf_wdata, busy
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, rf_rdata,
        output rd_gnt, rd_valid, rd_data, wr_ack,
               rf_ren, rf_raddr, rf_we, rf_waddr, rf_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_sched
// Description : Port scheduler for a 32-entry integer register file with one
//               read port and one write port.
//               - round-robin sharing of the read port among NREQ requesters
//               - write-back forwarded to the write port, x0 writes dropped
//               - zero-sweep of x1..x31 after reset (CLR_INIT=1)
//               Ports: clk, reset (sync, active-high), bus (slave modport of
//               regfile_port_sched_if carrying all request/RF signals).
//               Optional macro REGFILE_SCHED_BYPASS_EN: a read granted in the
//               same cycle as a write to the same nonzero register returns
//               the new write data instead of the register file's old value.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_sched #(
    parameter int NREQ     = 2,
    parameter int XLEN     = 32,
    parameter int CLR_INIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_port_sched_if.slave  bus
);
    localparam int         c_PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;
    localparam logic [4:0] c_LAST_REG = 5'd31;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [4:0]         r_sweep;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_win;
    logic               w_found;
    logic [4:0]         w_win_addr;
    logic [NREQ-1:0]    w_gnt;
    logic [NREQ-1:0]    r_valid;
    logic               r_zero;
    logic [XLEN-1:0]    w_ret_data;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= (CLR_INIT != 0) ? c_ST_INIT : c_ST_RUN;
            r_sweep <= 5'd1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_INIT)
                r_sweep <= r_sweep + 5'd1;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT: if (r_sweep == c_LAST_REG) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  w_state_nxt = c_ST_RUN;
            default:   w_state_nxt = c_ST_RUN;
        endcase
    end

    // ---------------- round-robin search ----------------
    // Two passes: requesters at or above the pointer first, then the ones
    // below it, which is the modulo-NREQ wrap without a divider.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && (i >= int'(r_ptr)) && bus.rd_req[i]) begin
                w_found    = 1'b1;
                w_win      = c_PTR_W'(i);
                w_win_addr = bus.rd_addr[5*i +: 5];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && (i < int'(r_ptr)) && bus.rd_req[i]) begin
                w_found    = 1'b1;
                w_win      = c_PTR_W'(i);
                w_win_addr = bus.rd_addr[5*i +: 5];
            end
        end
    end

    // ---------------- output logic ----------------
    // Strobes are masked while reset is asserted so nothing is issued to the
    // register file during a mid-operation reset.
    always_comb begin
        w_gnt         = '0;
        bus.rf_ren    = 1'b0;
        bus.rf_raddr  = '0;
        bus.wr_ack    = 1'b0;
        bus.rf_we     = 1'b0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.busy      = (r_state == c_ST_INIT);
        if (!reset) begin
            case (r_state)
                c_ST_INIT: begin
                    bus.rf_we    = 1'b1;
                    bus.rf_waddr = r_sweep;
                end
                c_ST_RUN: begin
                    if (w_found) begin
                        w_gnt[w_win] = 1'b1;
                        bus.rf_ren   = 1'b1;
                        bus.rf_raddr = w_win_addr;
                    end
                    bus.wr_ack   = bus.wr_req;
                    bus.rf_we    = bus.wr_req && (bus.wr_addr != 5'd0);
                    bus.rf_waddr = bus.wr_addr;
                    bus.rf_wdata = bus.wr_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_gnt = w_gnt;

    // ---------------- pointer and read-return tracking ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_valid <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_valid <= w_gnt;
            if (|w_gnt) begin
                r_zero <= (w_win_addr == 5'd0);
                r_ptr  <= (w_win == c_PTR_W'(NREQ - 1)) ? '0 : w_win + c_PTR_W'(1);
            end
        end
    end

`ifdef REGFILE_SCHED_BYPASS_EN
    logic            r_byp_hit;
    logic [XLEN-1:0] r_byp_data;

    // Write data captured in the grant cycle; the RF would return the old
    // value because it reads before it writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_hit <= (|w_gnt) && bus.wr_req && (bus.wr_addr == w_win_addr)
                         && (w_win_addr != 5'd0);
            if (|w_gnt)
                r_byp_data <= bus.wr_data;
        end
    end

    assign w_ret_data = r_byp_hit ? r_byp_data : bus.rf_rdata;
`else
    assign w_ret_data = bus.rf_rdata;
`endif

    assign bus.rd_valid = reset ? '0 : r_valid;
    // x0 always reads as zero whatever the storage holds.
    assign bus.rd_data  = (reset || (r_valid == '0) || r_zero) ? '0 : w_ret_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_port_sched
// Description : Self-checking bench for regfile_port_sched (NREQ=2, XLEN=32,
//               CLR_INIT=1). Directed stimulus pushes expected read returns
//               into a scoreboard queue; a monitor pops and compares them
//               whenever rd_valid is presented. A small register-file model
//               (read-before-write, x0 storage reads as all ones) answers the
//               read port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_port_sched;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errs   = 0;

    logic [33:0] sb[$];             // {expected rd_valid, expected rd_data}
    logic [31:0] mem [32];
    logic [31:0] r_model_rdata;

    always #5 clk = ~clk;

    regfile_port_sched_if #(.NREQ(2), .XLEN(32)) bus ();

    regfile_port_sched #(.NREQ(2), .XLEN(32), .CLR_INIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register-file model: synchronous read, old data on same-address write.
    always @(posedge clk) begin
        if (bus.rf_ren)
            r_model_rdata <= (bus.rf_raddr == 5'd0) ? 32'hFFFF_FFFF : mem[bus.rf_raddr];
        if (bus.rf_we)
            mem[bus.rf_waddr] <= bus.rf_wdata;
    end
    assign bus.rf_rdata = r_model_rdata;

    task automatic check(input string name, input logic [63:0] exp, input logic [63:0] act);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read cycle with inputs already driven: checks the grant and queues
    // the expected return.
    task automatic rd_step(input logic [1:0] egnt, input logic [4:0] eraddr,
                           input logic push, input logic [31:0] edata);
        @(negedge clk);
        check("rd_gnt", 64'(egnt), 64'(bus.rd_gnt));
        check("rf_ren", 64'(|egnt), 64'(bus.rf_ren));
        if (egnt != 2'b00)
            check("rf_raddr", 64'(eraddr), 64'(bus.rf_raddr));
        if (push)
            sb.push_back({egnt, edata});
        tick();
    endtask

    task automatic wr_step(input logic [4:0] addr, input logic [31:0] data);
        bus.wr_req  = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        check("wr_ack", 64'd1, 64'(bus.wr_ack));
        check("rf_we", 64'(addr != 5'd0), 64'(bus.rf_we));
        if (addr != 5'd0)
            check("rf_waddr_wdata", {27'd0, addr, data}, {27'd0, bus.rf_waddr, bus.rf_wdata});
        tick();
        bus.wr_req = 1'b0;
    endtask

    // Zero-sweep with both requesters asking: no grant may appear.
    task automatic sweep_check();
        bus.rd_req  = 2'b11;
        bus.rd_addr = {5'd6, 5'd5};
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            check("sweep_ctl", {57'd0, 1'b1, 1'b1, 5'(k)},
                  {57'd0, bus.busy, bus.rf_we, bus.rf_waddr});
            check("sweep_gnt_wdata", 64'd0, {30'd0, bus.rd_gnt, bus.rf_wdata});
            tick();
        end
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("busy_after_sweep", 64'd0, 64'(bus.busy));
        tick();
    endtask

    // Monitor: compares every presented read return against the scoreboard.
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (bus.rd_valid !== 2'b00) begin
                if (sb.size() == 0) begin
                    check("rd_valid_unexpected", 64'd0, 64'(bus.rd_valid));
                end else begin
                    e = sb.pop_front();
                    check("rd_valid", 64'(e[33:32]), 64'(bus.rd_valid));
                    check("rd_data", 64'(e[31:0]), 64'(bus.rd_data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [1:0]  t2_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] t2_data [4] = '{32'h55, 32'h66, 32'h55, 32'h66};
    logic [4:0]  t2_addr [4] = '{5'd5, 5'd6, 5'd5, 5'd6};

    initial begin
        reset       = 1'b1;
        bus.rd_req  = 2'b11;
        bus.rd_addr = '0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (2) @(posedge clk);
        // Reset values while reset is held
        @(negedge clk);
        check("reset_busy", 64'd1, 64'(bus.busy));
        check("reset_strobes", 64'd0,
              {58'd0, bus.rd_gnt, bus.rd_valid, bus.wr_ack, bus.rf_ren});
        check("reset_we_data", 64'd0, {31'd0, bus.rf_we, bus.rd_data});
        tick();
        reset = 1'b0;

        // T1: zero-sweep
        sweep_check();

        // Preload through the write port; x0 write is acked and dropped (T3)
        wr_step(5'd5, 32'h55);
        wr_step(5'd6, 32'h66);
        wr_step(5'd7, 32'h0000_AAAA);
        wr_step(5'd0, 32'hDEAD_BEEF);

        // T2: contention, both held
        bus.rd_req  = 2'b11;
        bus.rd_addr = {5'd6, 5'd5};
        for (int k = 0; k < 4; k++)
            rd_step(t2_gnt[k], t2_addr[k], 1'b1, t2_data[k]);
        bus.rd_req = 2'b00;

        // T3: read x0, model storage returns all ones
        bus.rd_req  = 2'b01;
        bus.rd_addr = {5'd0, 5'd0};
        rd_step(2'b01, 5'd0, 1'b1, 32'h0);
        bus.rd_req = 2'b00;

        // T4: same-cycle read and write of x7 (pointer now at requester 1)
        bus.rd_req  = 2'b10;
        bus.rd_addr = {5'd7, 5'd0};
        bus.wr_req  = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 32'h1234;
        @(negedge clk);
        check("t4_wr_ack_we", 64'h3, {62'd0, bus.wr_ack, bus.rf_we});
        check("t4_gnt", 64'h2, 64'(bus.rd_gnt));
`ifdef REGFILE_SCHED_BYPASS_EN
        sb.push_back({2'b10, 32'h1234});
`else
        sb.push_back({2'b10, 32'h0000_AAAA});
`endif
        tick();
        bus.wr_req = 1'b0;
        bus.rd_req = 2'b00;
        // Write has landed: read x7 again from requester 0
        bus.rd_req  = 2'b01;
        bus.rd_addr = {5'd0, 5'd7};
        rd_step(2'b01, 5'd7, 1'b1, 32'h1234);
        bus.rd_req = 2'b00;

        // T6: single requester 1 held, granted every cycle
        bus.rd_req  = 2'b10;
        bus.rd_addr = {5'd6, 5'd0};
        for (int k = 0; k < 3; k++)
            rd_step(2'b10, 5'd6, 1'b1, 32'h66);
        // Pointer wrapped back to 0: requester 0 wins, then requester 1
        bus.rd_req  = 2'b11;
        bus.rd_addr = {5'd5, 5'd5};
        rd_step(2'b01, 5'd5, 1'b1, 32'h55);
        rd_step(2'b10, 5'd5, 1'b1, 32'h55);
        bus.rd_req = 2'b00;

        // T5: grant on requester 0 (pointer -> 1), then reset next cycle
        bus.rd_req  = 2'b01;
        bus.rd_addr = {5'd0, 5'd5};
        rd_step(2'b01, 5'd5, 1'b0, 32'h0);
        bus.rd_req = 2'b00;
        reset      = 1'b1;
        @(negedge clk);
        check("t5_valid_dropped", 64'd0, {30'd0, bus.rd_valid, bus.rd_data});
        tick();
        reset = 1'b0;
        sweep_check();
        // Pointer cleared: requester 0 wins first; storage is zero again
        bus.rd_req  = 2'b11;
        bus.rd_addr = {5'd6, 5'd5};
        rd_step(2'b01, 5'd5, 1'b1, 32'h0);
        bus.rd_req = 2'b00;

        repeat (3) tick();
        check("scoreboard_empty", 64'd0, 64'(sb.size()));
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
